// File: rtl/patgen_pixel.sv
// Test-pattern pixel stage: turns timing-generator preDE/sync into registered RGB with DE/HSYNC/VSYNC delayed one DCLK.
// Optional white frame border on the active-area edges when PATGEN_BORDER_EN is defined.
module patgen_pixel #(
    parameter int BARW_VGA  = 80,
    parameter int BARW_XGA  = 128,
    parameter int BARW_SXGA = 160,
    parameter int CHK_BIT   = 5
) (
    input  logic        DCLK,
    input  logic        DRST_X,
    input  logic [1:0]  RESOL,
    input  logic [2:0]  MODE,
    input  logic        IN_HSYNC_X,
    input  logic        IN_VSYNC_X,
    input  logic        IN_preDE,
    input  logic [10:0] HCNT,
    input  logic [10:0] VCNT,
    output logic        DSP_HSYNC_X,
    output logic        DSP_VSYNC_X,
    output logic        DSP_DE,
    output logic [7:0]  DSP_R,
    output logic [7:0]  DSP_G,
    output logic [7:0]  DSP_B
);

    logic [10:0] xcnt;
    logic [10:0] ycnt;
    logic [10:0] bar_pos;
    logic [10:0] barw;
    logic [7:0]  fcnt;
    logic [2:0]  mode_q;
    logic [2:0]  bar_idx;
    logic        vs_d;
    logic        pde_d;
    logic        vs_fall;
    logic        pde_fall;
    logic [23:0] pix;
    logic        unused_ok;

    // HCNT/VCNT are for monitoring only; the datapath keeps its own counters.
    assign unused_ok = ^{HCNT, VCNT, xcnt[10], ycnt[10:8], fcnt[7:6]};

    always_comb begin
        case (RESOL)
            2'd1:    barw = 11'(BARW_XGA);
            2'd2:    barw = 11'(BARW_SXGA);
            default: barw = 11'(BARW_VGA);
        endcase
    end

    assign vs_fall  = vs_d & ~IN_VSYNC_X;
    assign pde_fall = pde_d & ~IN_preDE;

`ifdef PATGEN_BORDER_EN
    logic [10:0] hact;
    logic [10:0] vact;
    logic        on_border;

    always_comb begin
        case (RESOL)
            2'd1: begin
                hact = 11'd1024;
                vact = 11'd768;
            end
            2'd2: begin
                hact = 11'd1280;
                vact = 11'd1024;
            end
            default: begin
                hact = 11'd640;
                vact = 11'd480;
            end
        endcase
    end

    assign on_border = (xcnt == 11'd0) || (ycnt == 11'd0) ||
                       (xcnt == hact - 11'd1) || (ycnt == vact - 11'd1);
`endif

    // Bar colours follow the bit pattern of bar_idx: R off for 2,3,6,7, G off for 4..7, B off for odd bars.
    always_comb begin
        pix = 24'h0;
        case (mode_q)
            3'd0:    pix = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
            3'd1:    pix = {3{xcnt[7:0]}};
            3'd2:    pix = {24{xcnt[CHK_BIT] ^ ycnt[CHK_BIT]}};
            3'd3:    pix = {24{xcnt[9:4] == fcnt[5:0]}};
            3'd4:    pix = {3{ycnt[7:0]}};
            default: pix = 24'h0;
        endcase
`ifdef PATGEN_BORDER_EN
        if (on_border) begin
            pix = 24'hFFFFFF;
        end
`endif
    end

    always_ff @(posedge DCLK or negedge DRST_X) begin
        if (!DRST_X) begin
            DSP_HSYNC_X <= 1'b1;
            DSP_VSYNC_X <= 1'b1;
            DSP_DE      <= 1'b0;
            DSP_R       <= 8'h0;
            DSP_G       <= 8'h0;
            DSP_B       <= 8'h0;
            xcnt        <= 11'd0;
            ycnt        <= 11'd0;
            fcnt        <= 8'd0;
            mode_q      <= 3'd0;
            bar_idx     <= 3'd0;
            bar_pos     <= 11'd0;
            vs_d        <= 1'b1;
            pde_d       <= 1'b0;
        end else begin
            DSP_HSYNC_X <= IN_HSYNC_X;
            DSP_VSYNC_X <= IN_VSYNC_X;
            DSP_DE      <= IN_preDE;
            {DSP_R, DSP_G, DSP_B} <= IN_preDE ? pix : 24'h0;
            vs_d        <= IN_VSYNC_X;
            pde_d       <= IN_preDE;

            if (IN_preDE) begin
                xcnt <= xcnt + 11'd1;
                if (bar_pos == barw - 11'd1) begin
                    bar_pos <= 11'd0;
                    if (bar_idx != 3'd7) begin
                        bar_idx <= bar_idx + 3'd1;
                    end
                end else begin
                    bar_pos <= bar_pos + 11'd1;
                end
            end else begin
                xcnt    <= 11'd0;
                bar_pos <= 11'd0;
                bar_idx <= 3'd0;
            end

            // Frame start wins over a line end landing in the same cycle.
            if (vs_fall) begin
                ycnt   <= 11'd0;
                mode_q <= MODE;
                fcnt   <= fcnt + 8'd1;
            end else if (pde_fall) begin
                ycnt <= ycnt + 11'd1;
            end
        end
    end

endmodule

// File: tb/tb_patgen_pixel.sv
// Scoreboard bench for patgen_pixel: drives a small timing-generator model and compares every output cycle.
// Border expectations are included when PATGEN_BORDER_EN is defined.
module tb_patgen_pixel;

    localparam int CHK = 5;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } exp_t;

    logic        dclk;
    logic        drst_x;
    logic [1:0]  resol;
    logic [2:0]  mode;
    logic        in_hsync_x;
    logic        in_vsync_x;
    logic        in_pre_de;
    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic        dsp_hsync_x;
    logic        dsp_vsync_x;
    logic        dsp_de;
    logic [7:0]  dsp_r;
    logic [7:0]  dsp_g;
    logic [7:0]  dsp_b;

    exp_t  sb_q[$];
    string tag_q[$];
    int    checks;
    int    errors;

    int          mode_m;
    int          fcnt_m;
    int          y_m;
    int          resol_m;
    logic [23:0] bar_rgb [8];

    patgen_pixel dut (
        .DCLK        (dclk),
        .DRST_X      (drst_x),
        .RESOL       (resol),
        .MODE        (mode),
        .IN_HSYNC_X  (in_hsync_x),
        .IN_VSYNC_X  (in_vsync_x),
        .IN_preDE    (in_pre_de),
        .HCNT        (hcnt),
        .VCNT        (vcnt),
        .DSP_HSYNC_X (dsp_hsync_x),
        .DSP_VSYNC_X (dsp_vsync_x),
        .DSP_DE      (dsp_de),
        .DSP_R       (dsp_r),
        .DSP_G       (dsp_g),
        .DSP_B       (dsp_b)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    task automatic compare(input string tag, input exp_t obs, input exp_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t observed();
        return {dsp_hsync_x, dsp_vsync_x, dsp_de, dsp_r, dsp_g, dsp_b};
    endfunction

    task automatic checkOutput();
        exp_t  e;
        string t;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            compare(t, observed(), e);
        end
    endtask

    task automatic checkReset(input string tag);
        compare(tag, observed(), {1'b1, 1'b1, 1'b0, 24'h0});
    endtask

    // One DCLK of stimulus: check the previous cycle's result, then drive and record the expectation.
    task automatic applyStimulus(input logic hs, input logic vs, input logic pde,
                                 input logic [23:0] rgb, input string tag);
        @(negedge dclk);
        checkOutput();
        in_hsync_x = hs;
        in_vsync_x = vs;
        in_pre_de  = pde;
        sb_q.push_back({hs, vs, pde, pde ? rgb : 24'h0});
        tag_q.push_back(tag);
    endtask

    function automatic int barw_m();
        case (resol_m)
            1:       return 128;
            2:       return 160;
            default: return 80;
        endcase
    endfunction

    function automatic logic [23:0] exp_pixel(input int x, input int y);
        logic [23:0] p;
        int          idx;
        case (mode_m)
            0: begin
                idx = x / barw_m();
                if (idx > 7) idx = 7;
                p = bar_rgb[idx];
            end
            1: p = {3{8'(x)}};
            2: p = ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
            3: p = (((x >> 4) & 63) == (fcnt_m & 63)) ? 24'hFFFFFF : 24'h0;
            4: p = {3{8'(y)}};
            default: p = 24'h0;
        endcase
`ifdef PATGEN_BORDER_EN
        begin
            int hact;
            int vact;
            case (resol_m)
                1:       begin hact = 1024; vact = 768;  end
                2:       begin hact = 1280; vact = 1024; end
                default: begin hact = 640;  vact = 480;  end
            endcase
            if (x == 0 || y == 0 || x == hact - 1 || y == vact - 1) p = 24'hFFFFFF;
        end
`endif
        return p;
    endfunction

    task automatic vsync_pulse();
        mode_m = int'(mode);
        fcnt_m = (fcnt_m + 1) % 256;
        y_m    = 0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 24'h0, "vsync");
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 24'h0, "vback");
    endtask

    task automatic send_line(input int npix);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 24'h0, "hsync");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 24'h0, "hback");
        for (int x = 0; x < npix; x++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, exp_pixel(x, y_m),
                          $sformatf("m%0d_f%0d_x%0d_y%0d", mode_m, fcnt_m, x, y_m));
        end
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 24'h0, "hfront");
        if (npix > 0) y_m++;
    endtask

    initial begin
        bar_rgb = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        checks = 0;
        errors = 0;
        mode_m = 0;
        fcnt_m = 0;
        y_m    = 0;
        resol_m = 0;
        drst_x = 1'b0;
        resol  = 2'd0;
        mode   = 3'd0;
        in_hsync_x = 1'b1;
        in_vsync_x = 1'b1;
        in_pre_de  = 1'b0;
        hcnt = 11'd0;
        vcnt = 11'd0;

        // Reset held with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge dclk);
            mode       = 3'($urandom);
            in_hsync_x = 1'($urandom);
            in_vsync_x = 1'($urandom);
            in_pre_de  = 1'($urandom);
            hcnt       = 11'($urandom);
            vcnt       = 11'($urandom);
            @(posedge dclk);
            #1 checkReset("reset_hold");
        end
        @(negedge dclk);
        mode       = 3'd0;
        in_hsync_x = 1'b0;
        in_vsync_x = 1'b1;
        in_pre_de  = 1'b1;
        drst_x     = 1'b1;
        #1 checkReset("release_no_clk");
        @(negedge dclk);
        in_hsync_x = 1'b1;
        in_pre_de  = 1'b0;

        // Colour bars at 640 active, alignment of sync and DE checked every cycle.
        $display("[TB] colour bars RESOL=0");
        vsync_pulse();
        send_line(640);
        send_line(640);

        // Mode request mid-frame must not take effect until the next frame start.
        $display("[TB] mode latch");
        mode = 3'd2;
        send_line(640);
        vsync_pulse();
        for (int l = 0; l < 34; l++) send_line(64);

        // Scrolling bar across frames, 64-frame wrap and fcnt 255 -> 0.
        $display("[TB] scroll");
        mode = 3'd3;
        for (int f = 0; f < 3; f++) begin
            vsync_pulse();
            send_line(128);
        end
        for (int f = 0; f < 59; f++) vsync_pulse();
        send_line(128);
        for (int f = 0; f < 191; f++) vsync_pulse();
        send_line(1024);
        vsync_pulse();
        send_line(128);

        // Vertical ramp.
        mode = 3'd4;
        vsync_pulse();
        for (int l = 0; l < 3; l++) send_line(16);

        // Reset mid-line during a horizontal ramp.
        $display("[TB] reset mid-line");
        mode = 3'd1;
        vsync_pulse();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 24'h0, "hsync");
        for (int x = 0; x <= 300; x++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, exp_pixel(x, y_m),
                          $sformatf("ramp_x%0d", x));
        end
        #2 drst_x = 1'b0;
        #1 checkReset("async_reset");
        sb_q.delete();
        tag_q.delete();
        @(negedge dclk);
        in_pre_de = 1'b0;
        resol     = 2'd2;
        @(negedge dclk);
        #1 checkReset("reset_resol_change");
        @(negedge dclk);
        drst_x  = 1'b1;
        resol_m = 2;
        mode_m  = 0;
        fcnt_m  = 0;
        y_m     = 0;

        // MODE=1 is requested but bars stay until the next frame start.
        $display("[TB] colour bars RESOL=2 after reset");
        send_line(1280);
        send_line(1280);
        vsync_pulse();
        send_line(300);

        applyStimulus(1'b1, 1'b1, 1'b0, 24'h0, "flush");
        @(negedge dclk);
        checkOutput();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/patgen_pixel.md
Name: patgen_pixel

Overview:
- Display-side stage directly downstream of the sync/timing generator.
- Consumes the timing generator's HCNT/VCNT/preDE/sync outputs and produces a registered 24-bit RGB test pattern.
- Delays DE, HSYNC and VSYNC by one DCLK so all outputs are mutually aligned at the display interface.
- Pattern mode is selectable and latched once per frame.

Parameters:
- BARW_VGA, 80, colour-bar width in pixels for RESOL=0 (640 active)
- BARW_XGA, 128, colour-bar width for RESOL=1 (1024 active)
- BARW_SXGA, 160, colour-bar width for RESOL=2 (1280 active); RESOL=3 uses BARW_VGA
- CHK_BIT, 5, checkerboard square size exponent (2^CHK_BIT pixels)

Ports:
- DCLK  in  1  pixel clock; single clock domain
- DRST_X  in  1  reset, asynchronous assert, active-low
- RESOL  in  2  resolution select; static except under reset
- MODE  in  3  requested pattern; sampled at frame start
- IN_HSYNC_X  in  1  HSYNC from timing generator (active-low)
- IN_VSYNC_X  in  1  VSYNC from timing generator (active-low)
- IN_preDE  in  1  pre-data-enable; high one cycle before each active pixel
- HCNT  in  11  horizontal counter (monitor only, unused by datapath)
- VCNT  in  11  vertical counter (monitor only)
- DSP_HSYNC_X  out  1  HSYNC delayed 1 cycle
- DSP_VSYNC_X  out  1  VSYNC delayed 1 cycle
- DSP_DE  out  1  data enable = IN_preDE delayed 1 cycle
- DSP_R / DSP_G / DSP_B  out  8 each  pixel colour, valid when DSP_DE=1

Behaviour:
- Interface: one clock (DCLK); reset is asynchronous and active-low (DRST_X).
- Reset values: DSP_HSYNC_X=1, DSP_VSYNC_X=1, DSP_DE=0, RGB=0.
- Internal reset values: xcnt=0, ycnt=0, fcnt=0, mode_q=0, bar_idx=0, bar_pos=0, vs_d=1, pde_d=0.
- Latency: every output is registered exactly 1 DCLK after the inputs that produce it.
  - RGB is computed from the counters in the IN_preDE cycle, so DSP_DE and RGB for pixel x appear together.
- xcnt (11 bit):
  - IN_preDE=1: xcnt+1.
  - Else: 0.
  - The first active pixel therefore uses xcnt=0.
- Bar counters:
  - bar_pos counts 0..BARW-1 while IN_preDE=1; at BARW-1 it wraps to 0 and bar_idx increments.
  - bar_idx is 3-bit and saturates at 7.
  - Both clear when IN_preDE=0.
- ycnt (11 bit):
  - Increments on the IN_preDE falling edge (pde_d=1, IN_preDE=0).
  - Clears on the IN_VSYNC_X falling edge (vs_d=1, IN_VSYNC_X=0). Clear has priority if both occur in the same cycle.
- Frame start = IN_VSYNC_X falling edge. At frame start:
  - mode_q <= MODE.
  - fcnt (8 bit) increments, wrapping 255 -> 0.
  - A MODE change mid-frame has no visible effect until the next frame start.
- Pattern select (by mode_q):
  - 0 colour bars by bar_idx: white, yellow, cyan, green, magenta, red, blue, black. Colour components are 0xFF or 0x00.
  - 1 horizontal grey ramp: R=G=B=xcnt[7:0] (wraps every 256 px).
  - 2 checkerboard: white if xcnt[CHK_BIT]^ycnt[CHK_BIT], else black.
  - 3 scrolling bar: white where xcnt[9:4]==fcnt[5:0], else black. Moves 16 px per frame and wraps after 64 frames.
  - 4 vertical grey ramp: R=G=B=ycnt[7:0].
  - 5..7: black.
- Blanking: RGB registered to 0 whenever IN_preDE=0, regardless of mode.
- Reset mid-frame: all state clears immediately. After release:
  - mode_q stays 0 until the next VSYNC falling edge.
  - ycnt restarts at 0 on the first preDE falling edge, so the partial frame after release is offset. This is accepted.
- Sync passthrough: sync outputs are a pure 1-cycle delay, with no edge-shape modification.

Optional Feature:
- Macro: PATGEN_BORDER_EN.
- Defined:
  - Active pixels with xcnt==0, ycnt==0, xcnt==HACT-1 or ycnt==VACT-1 are forced to R=G=B=0xFF, overriding mode.
  - HACT/VACT come from RESOL: 640/480, 1024/768, 1280/1024 (3 -> 640/480).
  - Comparators are added for the edge tests.
- Undefined: no border logic is present; output is pure pattern.

Test Plan:
- Reset: hold DRST_X=0 with random inputs -> HSYNC_X=VSYNC_X=1, DE=0, RGB=0; asynchronous assertion releases nothing until DCLK.
- Alignment: drive the timing-generator model with RESOL=0, MODE=0 -> DSP_DE equals IN_preDE delayed 1 cycle. DSP_HSYNC_X and DSP_VSYNC_X equal their inputs delayed 1 cycle. RGB=0 whenever DE=0.
- Colour bars at RESOL=0 -> pixels 0..79 FFFFFF, 80..159 FFFF00, 160..239 00FFFF, ..., 560..639 000000. Repeat at RESOL=2 with 160-px bars.
- Mode latch: change MODE 0 -> 2 mid-frame -> current frame stays bars. The next frame is a checkerboard with pixel (32,0)=white and (32,32)=black.
- Scroll: MODE=3 over 3 frames -> white run at x=16f..16f+15 for fcnt=f. After 64 frames the run returns to x=0; fcnt wraps 255 -> 0 without glitch.
- Reset mid-line: assert DRST_X at xcnt=300 with MODE=1 -> outputs go to reset values immediately. After release, mode_q=0 (bars) until the next VSYNC falling edge. With PATGEN_BORDER_EN, row 0 is all FFFFFF.
